// File: rtl/uart_dbg_bridge_pkg.sv
// Shared constants, state encodings and sizing helper for the UART debug bridge.
package dbg_bridge_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'hA5;
    localparam logic [7:0] CMD_SAMPLE = 8'hC3;
    localparam logic [7:0] RSP_HDR    = 8'h5A;
    localparam logic [7:0] RSP_NAK    = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_SETTLE,
        ST_CAPTURE,
        ST_TX_HDR,
        ST_TX_DATA,
        ST_TX_WAIT
    } state_t;

    typedef enum logic [2:0] {
        TX_S_IDLE,
        TX_S_SEND,
        TX_S_START,
        TX_S_GAP,
        TX_S_WAIT
    } tx_state_t;

    function automatic int ceil_div8(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_dbg_bridge_if.sv
// Byte-level link between the uart core and the debug bridge.
interface uart_dbg_bridge_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    // uart core side
    modport master (output rx_valid, rx_data, rx_error, tx_busy,
                    input  tx_start, tx_data);
    // bridge side
    modport slave  (input  rx_valid, rx_data, rx_error, tx_busy,
                    output tx_start, tx_data);
endinterface

// File: rtl/uart_dbg_bridge_tx_seq.sv
// Byte serialiser: issues len_i bytes to the uart with the tx_start/tx_busy handshake.
//   state      | meaning
//   TX_S_IDLE  | waiting for start_i
//   TX_S_SEND  | waiting for tx_busy low, then latches byte_i and requests it
//   TX_S_START | tx_start high for this single cycle
//   TX_S_GAP   | one cycle for the uart to raise tx_busy
//   TX_S_WAIT  | byte in flight; done_o when the last one completes
module dbg_tx_seq
    import dbg_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] len_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       shift_o,
    output logic       last_o,
    output logic       done_o
);

    tx_state_t  st_q, st_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= TX_S_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        shift_o    = 1'b0;
        done_o     = 1'b0;
        case (st_q)
            TX_S_IDLE: if (start_i && len_i != 8'd0) begin
                cnt_d = len_i;
                st_d  = TX_S_SEND;
            end
            TX_S_SEND: if (!tx_busy_i) begin
                tx_start_d = 1'b1;
                tx_data_d  = byte_i;
                shift_o    = 1'b1;
                cnt_d      = cnt_q - 8'd1;
                st_d       = TX_S_START;
            end
            TX_S_START: st_d = TX_S_GAP;
            TX_S_GAP:   st_d = TX_S_WAIT;
            TX_S_WAIT: if (!tx_busy_i) begin
                if (cnt_q == 8'd0) begin
                    done_o = 1'b1;
                    st_d   = TX_S_IDLE;
                end else begin
                    st_d = TX_S_SEND;
                end
            end
            default: st_d = TX_S_IDLE;
        endcase
    end

    assign last_o     = (cnt_q == 8'd1);
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/uart_dbg_bridge.sv
// Framed UART-to-DUT debug bridge: WRITE drives dut_in, SAMPLE/WRITE reply with dut_out.
// Define DBG_BRIDGE_CSUM_EN to require a trailing XOR byte on WRITE and append one to replies.
//   state      | meaning
//   ST_IDLE    | waiting for a command byte
//   ST_RX_DATA | collecting WRITE payload, inter-byte timeout running
//   ST_SETTLE  | letting the DUT settle after dut_in is applied
//   ST_CAPTURE | latching dut_out into the response buffer
//   ST_TX_HDR  | header (or NAK) byte being issued
//   ST_TX_DATA | response data bytes being issued
//   ST_TX_WAIT | final byte in flight
module uart_dbg_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int OUT_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int RX_TIMEOUT    = 120000
) (
    input  logic                 iCE_CLK,
    input  logic                 rst_n,
    uart_dbg_bridge_if.slave     uart,
    output logic [IN_WIDTH-1:0]  dut_in,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    localparam int IN_BYTES  = ceil_div8(IN_WIDTH);
    localparam int OUT_BYTES = ceil_div8(OUT_WIDTH);
`ifdef DBG_BRIDGE_CSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif
    localparam int STW       = IN_BYTES * 8;
    localparam int RSP_BYTES = OUT_BYTES + 1 + CSUM_BYTES;
    localparam int RSW       = RSP_BYTES * 8;
    localparam int GAP_W     = $clog2(RX_TIMEOUT + 1);
    localparam int SET_W     = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0]       IN_BYTES4  = 4'(IN_BYTES);
    localparam logic [3:0]       RX_LAST    = 4'(IN_BYTES - 1 + CSUM_BYTES);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(RX_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [STW-1:0]      stage_q, stage_d;
    logic [3:0]          idx_q, idx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [IN_WIDTH-1:0] dut_in_q, dut_in_d;
    logic [RSW-1:0]      rsp_q, rsp_d, rsp_load;
    logic [7:0]          err_q, err_d;
    logic                err_inc, csum_ok;
    logic                seq_start, seq_shift, seq_last, seq_done;
    logic [7:0]          seq_len;

`ifdef DBG_BRIDGE_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n)
            csum_q <= '0;
        else if (uart.rx_valid && !uart.rx_error)
            csum_q <= (state_q == ST_IDLE) ? CMD_WRITE : (csum_q ^ uart.rx_data);
    end

    assign csum_ok = ((csum_q ^ uart.rx_data) == 8'h00);
`else
    assign csum_ok = 1'b1;
`endif

    // Response image, LSB byte first: header, zero-padded sample, optional XOR.
    always_comb begin
        rsp_load                  = '0;
        rsp_load[7:0]             = RSP_HDR;
        rsp_load[8 +: OUT_WIDTH]  = dut_out;
`ifdef DBG_BRIDGE_CSUM_EN
        rsp_load[RSW-8 +: 8] = RSP_HDR;
        for (int i = 0; i < OUT_BYTES; i++)
            rsp_load[RSW-8 +: 8] = rsp_load[RSW-8 +: 8] ^ rsp_load[8 + 8*i +: 8];
`endif
    end

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            settle_q <= '0;
            dut_in_q <= '0;
            rsp_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            settle_q <= settle_d;
            dut_in_q <= dut_in_d;
            rsp_q    <= rsp_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        settle_d  = settle_q;
        dut_in_d  = dut_in_q;
        rsp_d     = rsp_q;
        err_inc   = 1'b0;
        seq_start = 1'b0;
        seq_len   = 8'(RSP_BYTES);
        case (state_q)
            ST_IDLE: begin
                if (uart.rx_error) begin
                    err_inc = 1'b1;
                end else if (uart.rx_valid) begin
                    if (uart.rx_data == CMD_WRITE) begin
                        state_d = ST_RX_DATA;
                        idx_d   = '0;
                        gap_d   = GAP_RELOAD;
                    end else if (uart.rx_data == CMD_SAMPLE) begin
                        state_d  = ST_SETTLE;
                        settle_d = SET_RELOAD;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_RX_DATA: begin
                if (uart.rx_error) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else if (uart.rx_valid) begin
                    gap_d = GAP_RELOAD;
                    if (idx_q < IN_BYTES4)
                        stage_d = STW'({uart.rx_data, stage_q} >> 8);
                    if (idx_q == RX_LAST) begin
                        if (csum_ok) begin
                            dut_in_d = stage_d[IN_WIDTH-1:0];
                            settle_d = SET_RELOAD;
                            state_d  = ST_SETTLE;
                        end else begin
                            err_inc     = 1'b1;
                            rsp_d       = '0;
                            rsp_d[7:0]  = RSP_NAK;
                            seq_start   = 1'b1;
                            seq_len     = 8'd1;
                            state_d     = ST_TX_HDR;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (gap_q == '0) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_CAPTURE;
                else                settle_d = settle_q - SET_W'(1);
            end
            ST_CAPTURE: begin
                rsp_d     = rsp_load;
                seq_start = 1'b1;
                state_d   = ST_TX_HDR;
            end
            ST_TX_HDR:  if (seq_shift) state_d = seq_last ? ST_TX_WAIT : ST_TX_DATA;
            ST_TX_DATA: if (seq_shift && seq_last) state_d = ST_TX_WAIT;
            ST_TX_WAIT: if (seq_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // Anything arriving outside IDLE/RX_DATA is dropped, never queued.
        if (state_q != ST_IDLE && state_q != ST_RX_DATA && (uart.rx_valid || uart.rx_error))
            err_inc = 1'b1;
        if (seq_shift)
            rsp_d = rsp_q >> 8;
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    logic       seq_tx_start;
    logic [7:0] seq_tx_data;

    dbg_tx_seq u_tx_seq (
        .clk        (iCE_CLK),
        .rst_n      (rst_n),
        .start_i    (seq_start),
        .len_i      (seq_len),
        .byte_i     (rsp_q[7:0]),
        .tx_busy_i  (uart.tx_busy),
        .tx_start_o (seq_tx_start),
        .tx_data_o  (seq_tx_data),
        .shift_o    (seq_shift),
        .last_o     (seq_last),
        .done_o     (seq_done)
    );

    assign uart.tx_start = seq_tx_start;
    assign uart.tx_data  = seq_tx_data;
    assign dut_in        = dut_in_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench: 8b/5b adder DUT and 16b/12b loopback DUT, each behind its own bridge.
module tb_uart_dbg_bridge;

    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_dbg_bridge_if ua();
    uart_dbg_bridge_if ub();

    logic [7:0]  din_a;
    logic [4:0]  dout_a;
    logic        busy_a;
    logic [7:0]  err_a;
    logic [15:0] din_b;
    logic [11:0] dout_b;
    logic        busy_b;
    logic [7:0]  err_b;

    assign dout_a = {1'b0, din_a[3:0]} + {1'b0, din_a[7:4]};
    assign dout_b = din_b[11:0];

    uart_dbg_bridge #(.RX_TIMEOUT(TMO)) dut_a (
        .iCE_CLK (clk),
        .rst_n   (rst_n),
        .uart    (ua),
        .dut_in  (din_a),
        .dut_out (dout_a),
        .busy    (busy_a),
        .err_cnt (err_a)
    );

    uart_dbg_bridge #(.IN_WIDTH(16), .OUT_WIDTH(12), .RX_TIMEOUT(TMO)) dut_b (
        .iCE_CLK (clk),
        .rst_n   (rst_n),
        .uart    (ub),
        .dut_in  (din_b),
        .dut_out (dout_b),
        .busy    (busy_b),
        .err_cnt (err_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // uart stand-ins: busy rises just after tx_start and stays up for 12 cycles
    int bcnt_a = 0;
    int bcnt_b = 0;
    logic [7:0] cap_a[$];
    logic [7:0] cap_b[$];

    always @(negedge clk) begin
        if (ua.tx_start === 1'b1) begin
            chk("a_start_while_busy", 64'(ua.tx_busy), 64'd0);
            cap_a.push_back(ua.tx_data);
            bcnt_a = 12;
        end else if (bcnt_a > 0) begin
            bcnt_a--;
        end
        ua.tx_busy = (bcnt_a > 0);
    end

    always @(negedge clk) begin
        if (ub.tx_start === 1'b1) begin
            chk("b_start_while_busy", 64'(ub.tx_busy), 64'd0);
            cap_b.push_back(ub.tx_data);
            bcnt_b = 12;
        end else if (bcnt_b > 0) begin
            bcnt_b--;
        end
        ub.tx_busy = (bcnt_b > 0);
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic e);
        if (sel == 0) begin
            ua.rx_valid = v; ua.rx_data = d; ua.rx_error = e;
        end else begin
            ub.rx_valid = v; ub.rx_data = d; ub.rx_error = e;
        end
    endtask

    task automatic send(input int sel, input logic [7:0] b, input logic e = 1'b0);
        @(negedge clk);
        drive(sel, 1'b1, b, e);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_write(input int sel, input logic [15:0] data, input int nb);
        logic [7:0] x;
        x = 8'hA5;
        send(sel, 8'hA5);
        for (int i = 0; i < nb; i++) begin
            send(sel, data[8*i +: 8]);
            x = x ^ data[8*i +: 8];
        end
`ifdef DBG_BRIDGE_CSUM_EN
        send(sel, x);
`endif
    endtask

    task automatic wait_idle(input int sel, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (sel == 0) ? !busy_a : !busy_b;
        end
        chk({tag, "_idle"}, 64'(done), 64'd1);
    endtask

    // expected reply: 5A, data bytes LSB first, optional XOR of all of them
    task automatic expect_rsp(input int sel, input string tag, input logic [15:0] data, input int nb);
        logic [7:0] exp[$];
        logic [7:0] got[$];
        logic [7:0] x;
        wait_idle(sel, tag);
        x = 8'h5A;
        exp.push_back(8'h5A);
        for (int k = 0; k < nb; k++) begin
            exp.push_back(data[8*k +: 8]);
            x = x ^ data[8*k +: 8];
        end
`ifdef DBG_BRIDGE_CSUM_EN
        exp.push_back(x);
`endif
        if (sel == 0) begin got = cap_a; cap_a.delete(); end
        else          begin got = cap_b; cap_b.delete(); end
        chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'(exp[k]));
    endtask

    initial begin
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_din", 64'(din_a), 64'h0);
        chk("rst_a_busy", 64'(busy_a), 64'h0);
        chk("rst_a_err", 64'(err_a), 64'h0);
        chk("rst_a_tx_start", 64'(ua.tx_start), 64'h0);
        chk("rst_a_tx_data", 64'(ua.tx_data), 64'h0);
        chk("rst_b_din", 64'(din_b), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_write(0, 16'h0035, 1);
        chk("a_din_35", 64'(din_a), 64'h35);
        chk("a_busy_settle", 64'(busy_a), 64'h1);
        expect_rsp(0, "a_wr35", 16'h0008, 1);

        send_write(1, 16'h1234, 2);
        chk("b_din_1234", 64'(din_b), 64'h1234);
        expect_rsp(1, "b_wr1234", 16'h0234, 2);

        send(0, 8'hA5);
        repeat (150) @(negedge clk);
        chk("a_tmo_still_busy", 64'(busy_a), 64'h1);
        repeat (55) @(negedge clk);
        chk("a_tmo_idle", 64'(busy_a), 64'h0);
        chk("a_tmo_err", 64'(err_a), 64'h1);
        chk("a_tmo_din", 64'(din_a), 64'h35);
        chk("a_tmo_no_rsp", 64'(cap_a.size()), 64'h0);
        send_write(0, 16'h000F, 1);
        chk("a_din_0f", 64'(din_a), 64'h0F);
        expect_rsp(0, "a_wr0f", 16'h000F, 1);

        send(0, 8'h00);
        repeat (20) @(negedge clk);
        chk("a_bad_cmd_no_rsp", 64'(cap_a.size()), 64'h0);
        chk("a_bad_cmd_err", 64'(err_a), 64'h2);

        send(0, 8'hC3);
        send(0, 8'h77);
        chk("a_drop_in_settle_err", 64'(err_a), 64'h3);
        expect_rsp(0, "a_sample", 16'h000F, 1);
        chk("a_sample_din", 64'(din_a), 64'h0F);

        send(0, 8'hA5);
        send(0, 8'h11, 1'b1);
        chk("a_rxerr_idle", 64'(busy_a), 64'h0);
        chk("a_rxerr_err", 64'(err_a), 64'h4);
        chk("a_rxerr_din", 64'(din_a), 64'h0F);

        send(0, 8'hA5, 1'b1);
        chk("a_err_prio_idle", 64'(busy_a), 64'h0);
        chk("a_err_prio_err", 64'(err_a), 64'h5);

`ifdef DBG_BRIDGE_CSUM_EN
        send(0, 8'hA5);
        send(0, 8'h35);
        send(0, 8'h00);
        chk("a_nak_din", 64'(din_a), 64'h0F);
        chk("a_nak_err", 64'(err_a), 64'h6);
        wait_idle(0, "a_nak");
        chk("a_nak_len", 64'(cap_a.size()), 64'h1);
        chk("a_nak_byte", (cap_a.size() > 0) ? 64'(cap_a[0]) : 64'hDEAD, 64'hEE);
        cap_a.delete();
`endif

        send(0, 8'hC3);
        for (int c = 0; c < 3000 && cap_a.size() == 0; c++) @(negedge clk);
        chk("a_hdr_before_rst", 64'(cap_a.size()), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("a_midrst_tx_start", 64'(ua.tx_start), 64'h0);
        chk("a_midrst_din", 64'(din_a), 64'h0);
        chk("a_midrst_busy", 64'(busy_a), 64'h0);
        chk("a_midrst_err", 64'(err_a), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cap_a.delete();
        repeat (30) @(negedge clk);
        chk("a_after_rst_no_tx", 64'(cap_a.size()), 64'h0);
        send_write(0, 16'h0035, 1);
        chk("a_din_after_rst", 64'(din_a), 64'h35);
        expect_rsp(0, "a_after_rst", 16'h0008, 1);

        send(1, 8'hC3);
        expect_rsp(1, "b_sample_after_rst", 16'h0000, 2);
        chk("b_din_after_rst", 64'(din_b), 64'h0);

        repeat (260) send(0, 8'h00);
        chk("a_err_saturate", 64'(err_a), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
